// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB event arbiter: state encoding, sizes, colour
// bit offsets and small index helpers.
package rgb_pkg;

  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned LED_W   = 12;

  // Colour bit offsets inside each 3-bit LED group (LED k+1 at bits 3k..3k+2)
  localparam int unsigned BIT_B = 0;
  localparam int unsigned BIT_G = 1;
  localparam int unsigned BIT_R = 2;

  // Arbiter FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StGrant = 2'd1;
  localparam state_t StGap   = 2'd2;

  // Next index in the round-robin ring 0 -> 1 -> 2 -> 0
  function automatic logic [1:0] rr_next(input logic [1:0] cur);
    case (cur)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd2;
      default: rr_next = 2'd0;
    endcase
  endfunction

  // Index of a one-hot source vector; non-one-hot input maps to 0
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
    case (oh)
      3'b010:  onehot_to_idx = 2'd1;
      3'b100:  onehot_to_idx = 2'd2;
      default: onehot_to_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: chooses the first pending source after
// last_grant in ring order and returns it one-hot.
module rr_pick3
  import rgb_pkg::*;
(
  input  logic [NUM_SRC-1:0] pending_i,
  input  logic [1:0]         last_grant_i,
  output logic [NUM_SRC-1:0] pick_o,
  output logic               valid_o
);

  logic [1:0] idx;

  // Walk the ring starting just after the last owner; first hit wins
  always_comb begin
    pick_o = '0;
    idx    = last_grant_i;
    for (int k = 0; k < 3; k++) begin
      idx = rr_next(idx);
      if ((pick_o == '0) && pending_i[idx]) begin
        pick_o[idx] = 1'b1;
      end
    end
  end

  assign valid_o = |pending_i;

endmodule

// File: rtl/rgb_event_arbiter.sv
// Arbitrates three button-event sources for a shared 4-LED RGB bank. Each
// button rising edge queues a request; owners hold the bank for HOLD_CYCLES
// cycles (re-pressing the owner's button extends it), followed by a one-cycle
// blank gap before the next owner is picked round-robin.
module rgb_event_arbiter
  import rgb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] req,
  input  logic [LED_W-1:0]   src0_led,
  input  logic [LED_W-1:0]   src1_led,
  input  logic [LED_W-1:0]   src2_led,
  output logic [LED_W-1:0]   led_out,
  output logic [NUM_SRC-1:0] grant,
  output logic               busy
);

  localparam int unsigned   CntW    = $clog2(HOLD_CYCLES);
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] req_q, req_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         last_q, last_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pick;
  logic               pick_valid;

  assign rise  = req & ~req_q;
  assign req_d = req;

  rr_pick3 u_pick (
    .pending_i    (pending_q),
    .last_grant_i (last_q),
    .pick_o       (pick),
    .valid_o      (pick_valid)
  );

  // Next-state logic: request capture, ownership, hold counter, gap
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    pending_d = pending_q | rise;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d   = pick;
          cnt_d     = CntLoad;
          state_d   = StGrant;
          // Granting consumes the request, even if it re-rose this cycle
          pending_d = pending_d & ~pick;
        end
      end
      StGrant: begin
        // Owner re-press extends ownership instead of queueing again
        pending_d = pending_q | (rise & ~grant_q);
        if (|(rise & grant_q)) begin
          cnt_d = CntLoad;
        end else if (cnt_q == '0) begin
          state_d = StGap;
          grant_d = '0;
          last_d  = onehot_to_idx(grant_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset; last_grant=2 puts source 0 first
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      req_q     <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      last_q    <= 2'd2;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  // LED mux driven from the registered grant; blank when nobody owns the bank
  always_comb begin
    led_out = ({LED_W{grant_q[0]}} & src0_led)
            | ({LED_W{grant_q[1]}} & src1_led)
            | ({LED_W{grant_q[2]}} & src2_led);
  end

  assign grant = grant_q;
  assign busy  = (state_q == StGrant) || (state_q == StGap);

endmodule

// File: tb/tb_rgb_event_arbiter.sv
// Self-checking bench for rgb_event_arbiter with HOLD_CYCLES=8: directed
// scenarios plus randomized traffic against a behavioural ownership model.
module tb_rgb_event_arbiter;

  localparam int HOLD = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  req = '0;
  logic [11:0] src0_led = '0;
  logic [11:0] src1_led = '0;
  logic [11:0] src2_led = '0;
  logic [11:0] led_out;
  logic [2:0]  grant;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  rgb_event_arbiter #(
    .HOLD_CYCLES (HOLD)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req),
    .src0_led (src0_led),
    .src1_led (src1_led),
    .src2_led (src2_led),
    .led_out  (led_out),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: who owns the bank, how many owned cycles remain,
  // whether we are in the blank gap, and the set of waiting sources.
  bit [2:0]   m_pend;
  int         m_owner = -1;
  int         m_left  = 0;
  bit         m_gap   = 1'b0;
  int         m_last  = 2;
  logic [2:0] m_prev  = '0;

  function automatic void model_step();
    logic [2:0] rise;
    bit   [2:0] old;
    int         c;
    if (RST) begin
      m_pend = '0; m_owner = -1; m_left = 0; m_gap = 1'b0; m_last = 2; m_prev = '0;
    end else begin
      rise = req & ~m_prev;
      old  = m_pend;
      if (m_owner >= 0) begin
        m_pend = m_pend | (rise & ~(3'b001 << m_owner));
        if (rise[m_owner]) m_left = HOLD;
        else m_left = m_left - 1;
        if (m_left == 0) begin
          m_last = m_owner; m_owner = -1; m_gap = 1'b1;
        end
      end else if (m_gap) begin
        m_pend = m_pend | rise;
        m_gap  = 1'b0;
      end else begin
        m_pend = m_pend | rise;
        for (int j = 1; j <= 3; j++) begin
          c = (m_last + j) % 3;
          if (old[c]) begin
            m_owner = c; m_left = HOLD; m_pend[c] = 1'b0;
            break;
          end
        end
      end
      m_prev = req;
    end
  endfunction

  function automatic logic [2:0] m_grant();
    return (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
  endfunction

  function automatic logic [11:0] m_led();
    case (m_owner)
      0:       return src0_led;
      1:       return src1_led;
      2:       return src2_led;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic m_busy();
    return (m_owner >= 0) || m_gap;
  endfunction

  // One clock: model advances on the same edge the DUT samples, outputs read #1 later
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; req = '0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; req = 3'b111;
    src0_led = 12'hFFF; src1_led = 12'hFFF; src2_led = 12'hFFF;
    tick(); tick();
    checks++;
    if (grant !== 3'b000) begin
      failures++; $display("FAIL reset_grant: got %b want 000", grant);
    end
    checks++;
    if (led_out !== 12'h000) begin
      failures++; $display("FAIL reset_led: got %h want 000", led_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    req = '0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    src0_led = 12'h111; src1_led = 12'hA5A; src2_led = 12'h222;
    req = 3'b010;
    tick();
    req = 3'b000;
    checks++;
    if (grant !== 3'b000) begin
      failures++; $display("FAIL single_latency1: grant %b want 000", grant);
    end
    tick();
    checks++;
    if (grant !== 3'b010 || led_out !== 12'hA5A || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: grant=%b led=%h busy=%b want 010/a5a/1", grant, led_out, busy);
    end
    n = 1;
    for (int i = 0; i < 20 && grant == 3'b010; i++) begin
      tick();
      if (grant == 3'b010) n++;
    end
    checks++;
    if (n != HOLD) begin
      failures++; $display("FAIL single_hold: owned %0d cycles want %0d", n, HOLD);
    end
    checks++;
    if (led_out !== 12'h000 || busy !== 1'b1 || grant !== 3'b000) begin
      failures++;
      $display("FAIL single_gap: grant=%b led=%h busy=%b want 000/000/1", grant, led_out, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 3'b000) begin
      failures++; $display("FAIL single_idle: busy=%b grant=%b want 0/000", busy, grant);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] seq[$];
    logic [2:0] prev;
    int         busy_cnt;
    int         gcnt[3];
    do_reset();
    req = 3'b111;
    tick();
    req = 3'b000;
    prev = 3'b000; busy_cnt = 0; gcnt = '{0, 0, 0};
    for (int i = 0; i < 60; i++) begin
      tick();
      if (grant != 3'b000 && grant != prev) seq.push_back(grant);
      for (int s = 0; s < 3; s++) if (grant[s]) gcnt[s]++;
      // Busy span from first grant through the end of the third owner
      if (busy && !(seq.size() == 3 && grant == 3'b000)) busy_cnt++;
      prev = grant;
    end
    checks++;
    if (seq.size() != 3) begin
      failures++; $display("FAIL simul_count: %0d grants want 3", seq.size());
    end else begin
      checks++;
      if (seq[0] !== 3'b001 || seq[1] !== 3'b010 || seq[2] !== 3'b100) begin
        failures++;
        $display("FAIL simul_order: got %b,%b,%b want 001,010,100", seq[0], seq[1], seq[2]);
      end
    end
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (gcnt[s] != HOLD) begin
        failures++; $display("FAIL simul_hold%0d: %0d cycles want %0d", s, gcnt[s], HOLD);
      end
    end
    checks++;
    if (busy_cnt != 26) begin
      failures++; $display("FAIL simul_busy: %0d cycles want 26", busy_cnt);
    end
  endtask

  task automatic test_extension();
    int n;
    do_reset();
    src0_led = 12'($urandom);
    req = 3'b001;
    tick();
    req = 3'b000;
    for (int i = 0; i < 5 && grant != 3'b001; i++) tick();
    checks++;
    if (grant !== 3'b001) begin
      failures++; $display("FAIL ext_start: grant %b want 001", grant);
    end
    n = 1;
    for (int k = 0; k < 40; k++) begin
      req = (n == 5) ? 3'b001 : 3'b000;
      tick();
      if (grant == 3'b001) n++;
      else break;
    end
    req = 3'b000;
    checks++;
    if (n != 5 + HOLD) begin
      failures++; $display("FAIL ext_hold: owned %0d cycles want %0d", n, 5 + HOLD);
    end
  endtask

  task automatic test_queueing();
    int n;
    do_reset();
    req = 3'b100;
    tick();
    req = 3'b000;
    for (int i = 0; i < 5 && grant != 3'b100; i++) tick();
    checks++;
    if (grant !== 3'b100) begin
      failures++; $display("FAIL queue_start: grant %b want 100", grant);
    end
    n = 1;
    for (int k = 0; k < 40; k++) begin
      req = (n == 3) ? 3'b001 : 3'b000;
      tick();
      if (grant == 3'b100) n++;
      else break;
    end
    req = 3'b000;
    checks++;
    if (n != HOLD) begin
      failures++; $display("FAIL queue_nopreempt: owner held %0d cycles want %0d", n, HOLD);
    end
    checks++;
    if (grant !== 3'b000) begin
      failures++; $display("FAIL queue_gap: grant %b want 000", grant);
    end
    tick();
    checks++;
    if (grant !== 3'b000) begin
      failures++; $display("FAIL queue_idle: grant %b want 000", grant);
    end
    tick();
    checks++;
    if (grant !== 3'b001) begin
      failures++; $display("FAIL queue_next: grant %b want 001", grant);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit stray;
    do_reset();
    req = 3'b010;
    tick();
    req = 3'b000;
    for (int i = 0; i < 5 && grant != 3'b010; i++) tick();
    n = 1;
    while (n < 4 && grant == 3'b010) begin
      req = (n == 2) ? 3'b100 : 3'b000;
      tick();
      n++;
    end
    req = 3'b000;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (grant !== 3'b000 || led_out !== 12'h000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear: grant=%b led=%h busy=%b want 000/000/0", grant, led_out, busy);
    end
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (grant != 3'b000) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      failures++; $display("FAIL midrst_pending: grant seen %b want none", grant);
    end
    req = 3'b101;
    tick();
    req = 3'b000;
    tick();
    checks++;
    if (grant !== 3'b001) begin
      failures++; $display("FAIL midrst_order: grant %b want 001", grant);
    end
  endtask

  task automatic test_held();
    int starts;
    int owned;
    logic [2:0] prev;
    RST = 1'b1; req = 3'b010;
    tick(); tick();
    RST = 1'b0;
    starts = 0; owned = 0; prev = 3'b000;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (grant == 3'b010 && prev != 3'b010) starts++;
      if (grant == 3'b010) owned++;
      prev = grant;
    end
    req = 3'b000;
    checks++;
    if (starts != 1) begin
      failures++; $display("FAIL held_starts: %0d grants want 1", starts);
    end
    checks++;
    if (owned != HOLD) begin
      failures++; $display("FAIL held_owned: %0d cycles want %0d", owned, HOLD);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 2)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        src0_led = 12'($urandom); src1_led = 12'($urandom); src2_led = 12'($urandom);
      end
      RST = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (grant !== m_grant()) begin
        failures++; $display("FAIL rand_grant @%0d: got %b want %b", i, grant, m_grant());
      end
      checks++;
      if (led_out !== m_led()) begin
        failures++; $display("FAIL rand_led @%0d: got %h want %h", i, led_out, m_led());
      end
      checks++;
      if (busy !== m_busy()) begin
        failures++; $display("FAIL rand_busy @%0d: got %b want %b", i, busy, m_busy());
      end
      checks++;
      if (!$onehot0(grant)) begin
        failures++; $display("FAIL rand_onehot @%0d: got %b want at most one bit", i, grant);
      end
    end
    RST = 1'b0; req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_extension();
    test_queueing();
    test_reset_mid();
    test_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
